// File: rtl/regfile_pkg.sv
// Purpose: shared types, default geometry and byte-merge helper for the register file.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Default geometry of the display register file.
  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 5;
  localparam int NBYTE       = DATA_W_DFLT / 8;
  localparam int DEPTH       = 1 << ADDR_W_DFLT;

  // merge() works on the widest supported word; callers widen their
  // operands on the way in and truncate the result on the way out.
  localparam int MERGE_W = 1024;

  // Byte-wise merge: new byte where wen is set, old byte elsewhere.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0]   old_v,
    input logic [MERGE_W-1:0]   new_v,
    input logic [MERGE_W/8-1:0] wen
  );
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MERGE_W / 8; i++) begin
      if (wen[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Purpose: one registered read port with enable-hold, write bypass and zero forcing.
// Latency: 1 cycle from sampled raddr/rd_en to rdata.
// Backpressure: none; rd_en low simply holds the last value.
// Ports: clk/resetn; rd_en/raddr request; rd_word = array word at raddr;
//        clearing, wr_act/waddr/wen/wdata = same-cycle write for bypass; rdata out.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [DATA_W-1:0]   rd_word,
  input  logic                clearing,
  input  logic                wr_act,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] wen,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic force_zero;
  logic byp_hit;

  assign force_zero = clearing || ((ZERO_R0 != 0) && (raddr == '0));
  assign byp_hit    = wr_act && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (rd_en) begin
      if (force_zero) begin
        rdata <= '0;
      end else if (byp_hit) begin
        rdata <= DATA_W'(merge(MERGE_W'(rd_word), MERGE_W'(wdata), (MERGE_W/8)'(wen)));
      end else begin
        rdata <= rd_word;
      end
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// Purpose: multi-port register file with byte-lane writes, bypassed read ports and a clear sweep.
// Latency: writes land at the sampling edge; reads are 1 cycle; clear sweep takes DEPTH cycles.
// Backpressure: clr_busy high means user writes are dropped and reads return 0.
// Ports: clk/resetn; wen/waddr/wdata write port; rd_en/raddr/rdata packed read ports;
//        clr_req/clr_busy clear control; test_addr/test_data unbypassed debug read.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_W/8-1:0]   wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic [ADDR_W-1:0]     test_addr,
  output logic [DATA_W-1:0]     test_data
);

  localparam int N_ENTRY = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   mem [N_ENTRY];
  logic                wr_act;
  logic                clearing;

  assign clearing = (state_q == CLEAR);
  assign clr_busy = clearing;

  // A write counts only in IDLE, with at least one lane set, and not to a
  // hard-wired zero entry. Reset also blocks it so a reset edge never
  // commits a stray user write.
  assign wr_act = resetn && !clearing && (wen != '0) &&
                  !((ZERO_R0 != 0) && (waddr == '0));

  // Clear FSM: state/pointer register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Clear FSM: next state. The pointer wraps to 0 on the final sweep
  // cycle, so IDLE always sits with a zeroed pointer.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(N_ENTRY - 1)) state_d = IDLE;
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Array: single write port, no reset; the sweep provides initialisation.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_act) begin
      mem[waddr] <= DATA_W'(merge(MERGE_W'(mem[waddr]), MERGE_W'(wdata), (MERGE_W/8)'(wen)));
    end
  end

  assign test_data = ((ZERO_R0 != 0) && (test_addr == '0)) ? '0 : mem[test_addr];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [DATA_W-1:0] rd_word;
    assign rd_word = mem[raddr[p*ADDR_W +: ADDR_W]];

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) u_rd_port (
      .clk     (clk),
      .resetn  (resetn),
      .rd_en   (rd_en[p]),
      .raddr   (raddr[p*ADDR_W +: ADDR_W]),
      .rd_word (rd_word),
      .clearing(clearing),
      .wr_act  (wr_act),
      .waddr   (waddr),
      .wen     (wen),
      .wdata   (wdata),
      .rdata   (rdata[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_bank.sv
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  rd_en;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        clr_req;
  logic        clr_busy;
  logic [4:0]  test_addr;
  logic [31:0] test_data;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  regfile_bank #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_R0(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .raddr    (raddr),
    .rdata    (rdata),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .test_addr(test_addr),
    .test_data(test_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      test_addr = 5'(a);
      #1;
      check(tag, test_data, 32'h0);
    end
  endtask

  initial begin
    resetn = 1'b0; wen = '0; waddr = '0; wdata = '0;
    rd_en = '0; raddr = '0; clr_req = 1'b0; test_addr = '0;

    // Reset sweep
    step();
    check("rst_busy", {31'b0, clr_busy}, 32'h1);
    check("rst_rdata0", rdata[31:0], 32'h0);
    check("rst_rdata1", rdata[63:32], 32'h0);
    resetn = 1'b1;
    n = 1;
    while (clr_busy && n < 100) begin
      step();
      if (clr_busy) n++;
    end
    check("rst_busy_len", 32'(n), 32'd32);
    check_all_zero("rst_clear");

    // Byte-lane write
    waddr = 5'd3; wdata = 32'h11223344; wen = 4'hF;
    step();
    wdata = 32'hAABBCCDD; wen = 4'b0101;
    step();
    wen = '0; test_addr = 5'd3;
    #1;
    check("byte_lane", test_data, 32'h11BB33DD);

    // Bypass, full word
    rd_en = 2'b01; raddr = {5'd0, 5'd5};
    waddr = 5'd5; wdata = 32'hDEADBEEF; wen = 4'hF;
    step();
    check("byp_full", rdata[31:0], 32'hDEADBEEF);
    // Return entry 5 to zero, then bypass with two lanes
    rd_en = 2'b00; wdata = 32'h0; wen = 4'hF;
    step();
    rd_en = 2'b01; wdata = 32'hDEADBEEF; wen = 4'b0011;
    step();
    check("byp_half", rdata[31:0], 32'h0000BEEF);
    wen = '0; rd_en = '0;

    // Zero register
    waddr = 5'd0; wdata = 32'h12345678; wen = 4'hF;
    step();
    wen = '0; rd_en = 2'b10; raddr = {5'd0, 5'd5};
    step();
    check("zero_rd1", rdata[63:32], 32'h0);
    check("zero_p0_held", rdata[31:0], 32'h0000BEEF);
    test_addr = 5'd0;
    #1;
    check("zero_test", test_data, 32'h0);

    // Hold
    rd_en = 2'b01; raddr = {5'd0, 5'd3};
    step();
    check("hold_rd", rdata[31:0], 32'h11BB33DD);
    rd_en = 2'b00; waddr = 5'd3; wdata = 32'hCAFEF00D; wen = 4'hF;
    step();
    wen = '0;
    check("hold_keep", rdata[31:0], 32'h11BB33DD);
    test_addr = 5'd3;
    #1;
    check("hold_written", test_data, 32'hCAFEF00D);

    // Both ports on the same address
    rd_en = 2'b11; raddr = {5'd3, 5'd3};
    step();
    rd_en = 2'b00;
    check("dual_p0", rdata[31:0], 32'hCAFEF00D);
    check("dual_p1", rdata[63:32], 32'hCAFEF00D);

    // Clear sweep with dropped write and ignored re-request
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 1;
    while (clr_busy && n < 100) begin
      if (n == 3) clr_req = 1'b1;
      if (n == 5) begin
        waddr = 5'd31; wdata = 32'h55555555; wen = 4'hF; rd_en = 2'b01; raddr = {5'd0, 5'd3};
      end
      step();
      clr_req = 1'b0; wen = '0;
      if (n == 5) check("clr_rd_zero", rdata[31:0], 32'h0);
      rd_en = '0;
      if (clr_busy) n++;
    end
    check("clr_busy_len", 32'(n), 32'd32);
    test_addr = 5'd31;
    #1;
    check("clr_drop_wr", test_data, 32'h0);
    test_addr = 5'd3;
    #1;
    check("clr_entry3", test_data, 32'h0);
    // Write accepted in the first IDLE cycle
    waddr = 5'd9; wdata = 32'h99999999; wen = 4'hF;
    step();
    wen = '0; test_addr = 5'd9;
    #1;
    check("post_clr_wr", test_data, 32'h99999999);

    // Reset mid-sweep
    waddr = 5'd30; wdata = 32'hA5A5A5A5; wen = 4'hF;
    step();
    wen = '0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n = 1;
    while (n < 10) begin
      step();
      n++;
    end
    test_addr = 5'd30;
    #1;
    check("mid_partial", test_data, 32'hA5A5A5A5);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mid_rst_busy", {31'b0, clr_busy}, 32'h1);
    n = 1;
    while (clr_busy && n < 100) begin
      step();
      if (clr_busy) n++;
    end
    check("mid_rst_len", 32'(n), 32'd32);
    check_all_zero("mid_rst_clear");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
